// File: rtl/lector_salidas.sv
// lector_salidas: read-side engine for fabric output FIFOs 4-7.
// Pops non-empty FIFOs in round-robin order, one word in flight at a time.
// Each popped word goes out on a valid/ready stream tagged with its source
// port. Per-port counters track delivered words.
module lector_salidas #(
    parameter int data_width  = 10,
    parameter int count_width = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   enable,
    input  logic [7:0]             empty_fifos,
    input  logic [data_width-1:0]  FIFO_data_out4,
    input  logic [data_width-1:0]  FIFO_data_out5,
    input  logic [data_width-1:0]  FIFO_data_out6,
    input  logic [data_width-1:0]  FIFO_data_out7,
    output logic                   pop4,
    output logic                   pop5,
    output logic                   pop6,
    output logic                   pop7,
    input  logic                   ready_in,
    output logic                   valid_out,
    output logic [data_width-1:0]  data_out,
    output logic [1:0]             dest,
    input  logic                   clear_counts,
    output logic [count_width-1:0] count0,
    output logic [count_width-1:0] count1,
    output logic [count_width-1:0] count2,
    output logic [count_width-1:0] count3,
    output logic                   idle
);

    typedef enum logic [1:0] {IDLE, POP, CAPTURE, SEND} state_t;

    state_t                 state;
    logic [1:0]             sel;
    logic [1:0]             last;
    logic [3:0]             pop_q;
    logic [count_width-1:0] count_q [4];

    logic [3:0]            cand;
    logic [1:0]            base_ptr;
    logic [1:0]            idx;
    logic [1:0]            winner;
    logic                  found;
    logic [data_width-1:0] fifo_word;
    logic                  unused_low_flags;

    // Flags of FIFOs 0-3 belong to the input side and are not used here.
    assign unused_low_flags = ^empty_fifos[3:0];

    // Round-robin search starting after the last served port. At a SEND
    // transfer, the port being delivered becomes the new "last".
    always_comb begin
        // NOTE: every combinational output gets a default first, so no
        // path through the block leaves a value held (no latch).
        cand     = ~empty_fifos[7:4];
        base_ptr = (state == SEND) ? sel : last;
        found    = 1'b0;
        winner   = 2'd0;
        idx      = 2'd0;
        for (int i = 1; i <= 4; i++) begin
            idx = base_ptr + 2'(i);
            if (!found && cand[idx]) begin
                found  = 1'b1;
                winner = idx;
            end
        end
    end

    // Read-data mux for the FIFO selected by the word in flight.
    always_comb begin
        fifo_word = FIFO_data_out4;
        case (sel)
            2'd0: fifo_word = FIFO_data_out4;
            2'd1: fifo_word = FIFO_data_out5;
            2'd2: fifo_word = FIFO_data_out6;
            2'd3: fifo_word = FIFO_data_out7;
            default: fifo_word = FIFO_data_out4;
        endcase
    end

    // Control FSM, pop strobes, output capture and delivered-word counters.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            sel       <= 2'd0;
            last      <= 2'd3;
            pop_q     <= 4'b0000;
            valid_out <= 1'b0;
            data_out  <= '0;
            dest      <= 2'd0;
            idle      <= 1'b1;
            // NOTE: the counter array is only four registers, so resetting
            // it is cheap; a large storage array would normally stay unreset.
            for (int i = 0; i < 4; i++) begin
                count_q[i] <= '0;
            end
        end else begin
            // NOTE: non-blocking assignments keep every register update
            // based on the pre-edge values, regardless of statement order.
            pop_q <= 4'b0000;
            case (state)
                IDLE: begin
                    if (enable && found) begin
                        sel   <= winner;
                        pop_q <= 4'b0001 << winner;
                        state <= POP;
                        idle  <= 1'b0;
                    end
                end
                POP: begin
                    state <= CAPTURE;
                end
                CAPTURE: begin
                    data_out  <= fifo_word;
                    dest      <= sel;
                    valid_out <= 1'b1;
                    state     <= SEND;
                end
                SEND: begin
                    if (ready_in) begin
                        valid_out    <= 1'b0;
                        last         <= sel;
                        count_q[sel] <= count_q[sel] + 1'b1;
                        if (enable && found) begin
                            sel   <= winner;
                            pop_q <= 4'b0001 << winner;
                            state <= POP;
                        end else begin
                            state <= IDLE;
                            idle  <= 1'b1;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    idle  <= 1'b1;
                end
            endcase
            // Clear comes last so it overrides a coincident increment.
            if (clear_counts) begin
                for (int i = 0; i < 4; i++) begin
                    count_q[i] <= '0;
                end
            end
        end
    end

    assign pop4   = pop_q[0];
    assign pop5   = pop_q[1];
    assign pop6   = pop_q[2];
    assign pop7   = pop_q[3];
    assign count0 = count_q[0];
    assign count1 = count_q[1];
    assign count2 = count_q[2];
    assign count3 = count_q[3];

endmodule

// File: tb/tb_lector_salidas.sv
// Testbench for lector_salidas: behavioural FIFO model plus a scoreboard of
// expected (dest, data) words, and directed timing checks.
module tb_lector_salidas;

    localparam int DW = 10;
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          enable = 1'b0;
    logic          ready_in = 1'b0;
    logic          clear_counts = 1'b0;
    logic [7:0]    empty_fifos = 8'hFF;
    logic [DW-1:0] fd4 = '0, fd5 = '0, fd6 = '0, fd7 = '0;
    logic          pop4, pop5, pop6, pop7;
    logic          valid_out, idle;
    logic [DW-1:0] data_out;
    logic [1:0]    dest;
    logic [CW-1:0] count0, count1, count2, count3;

    lector_salidas #(.data_width(DW), .count_width(CW)) dut (
        .clk(clk), .reset(reset), .enable(enable), .empty_fifos(empty_fifos),
        .FIFO_data_out4(fd4), .FIFO_data_out5(fd5),
        .FIFO_data_out6(fd6), .FIFO_data_out7(fd7),
        .pop4(pop4), .pop5(pop5), .pop6(pop6), .pop7(pop7),
        .ready_in(ready_in), .valid_out(valid_out), .data_out(data_out),
        .dest(dest), .clear_counts(clear_counts),
        .count0(count0), .count1(count1), .count2(count2), .count3(count3),
        .idle(idle)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0]    dest;
        logic [DW-1:0] data;
    } item_t;

    item_t         exp_q[$];
    logic [DW-1:0] fq0[$], fq1[$], fq2[$], fq3[$];
    int            pop_cyc[$];
    int            cyc = 0;
    int            n_tests = 0;
    int            n_fail = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // FIFO model and scoreboard: a pop presents the next word from the
    // negedge of the pop cycle on; transfers are checked against exp_q.
    always @(negedge clk) begin : model
        logic [3:0] pops;
        item_t      it;
        pops = {pop7, pop6, pop5, pop4};
        if (reset && pops != 4'b0000) begin
            check("pop_onehot", $countones(pops), 1);
            pop_cyc.push_back(cyc);
            if (pops[0]) begin if (fq0.size() == 0) check("pop_on_empty4", 1, 0); else fd4 = fq0.pop_front(); end
            if (pops[1]) begin if (fq1.size() == 0) check("pop_on_empty5", 1, 0); else fd5 = fq1.pop_front(); end
            if (pops[2]) begin if (fq2.size() == 0) check("pop_on_empty6", 1, 0); else fd6 = fq2.pop_front(); end
            if (pops[3]) begin if (fq3.size() == 0) check("pop_on_empty7", 1, 0); else fd7 = fq3.pop_front(); end
        end
        if (reset && valid_out && ready_in) begin
            if (exp_q.size() == 0) begin
                check("unexpected_word", 1, 0);
            end else begin
                it = exp_q.pop_front();
                check("sb_dest", 32'(dest), 32'(it.dest));
                check("sb_data", 32'(data_out), 32'(it.data));
            end
        end
        empty_fifos = {fq3.size() == 0, fq2.size() == 0, fq1.size() == 0,
                       fq0.size() == 0, 4'b0101};
    end

    task automatic do_reset();
        @(posedge clk);
        #1;
        reset = 1'b0;
        enable = 1'b0;
        ready_in = 1'b0;
        clear_counts = 1'b0;
        fq0.delete(); fq1.delete(); fq2.delete(); fq3.delete();
        exp_q.delete();
        pop_cyc.delete();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    task automatic load(input int p, input logic [DW-1:0] d);
        case (p)
            0: fq0.push_back(d);
            1: fq1.push_back(d);
            2: fq2.push_back(d);
            default: fq3.push_back(d);
        endcase
    endtask

    task automatic expect_word(input int p, input logic [DW-1:0] d);
        item_t it;
        it.dest = 2'(p);
        it.data = d;
        exp_q.push_back(it);
    endtask

    task automatic wait_drain(input int max_cycles);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(exp_q.size() == 0 && idle) && n < max_cycles);
        if (n >= max_cycles) check("drain_timeout", 0, 1);
    endtask

    task automatic wait_valid(input int max_cycles);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!valid_out && n < max_cycles);
        if (!valid_out) check("valid_timeout", 0, 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset values.
        do_reset();
        @(negedge clk);
        check("rst_valid", valid_out, 0);
        check("rst_idle", idle, 1);
        check("rst_pops", {pop7, pop6, pop5, pop4}, 0);
        check("rst_data", data_out, 0);
        check("rst_dest", dest, 0);
        check("rst_count0", count0, 0);

        // Single word from FIFO 5: pop in cycle 1, valid in cycle 3.
        do_reset();
        enable = 1'b1;
        ready_in = 1'b1;
        load(1, 10'h2A5);
        expect_word(1, 10'h2A5);
        @(negedge clk);
        @(negedge clk);
        check("t1_pop5_c1", pop5, 1);
        check("t1_others_c1", {pop7, pop6, pop4}, 0);
        check("t1_idle_c1", idle, 0);
        @(negedge clk);
        check("t1_pop5_c2", pop5, 0);
        check("t1_valid_c2", valid_out, 0);
        @(negedge clk);
        check("t1_valid_c3", valid_out, 1);
        check("t1_data_c3", data_out, 10'h2A5);
        check("t1_dest_c3", dest, 1);
        @(negedge clk);
        check("t1_count1", count1, 1);
        wait_drain(20);

        // Two words per FIFO: round-robin order, one pop per 3 cycles.
        do_reset();
        enable = 1'b1;
        ready_in = 1'b1;
        for (int k = 0; k < 2; k++) begin
            for (int p = 0; p < 4; p++) begin
                load(p, 10'(p * 16 + k + 1));
                expect_word(p, 10'(p * 16 + k + 1));
            end
        end
        wait_drain(200);
        check("t2_count0", count0, 2);
        check("t2_count1", count1, 2);
        check("t2_count2", count2, 2);
        check("t2_count3", count3, 2);
        check("t2_idle", idle, 1);
        check("t2_npops", pop_cyc.size(), 8);
        for (int i = 1; i < pop_cyc.size(); i++) begin
            check("t2_pop_gap", pop_cyc[i] - pop_cyc[i-1], 3);
        end

        // Backpressure: output stable, no pops; next pop right after transfer.
        do_reset();
        enable = 1'b1;
        load(0, 10'h155);
        load(2, 10'h0AA);
        expect_word(0, 10'h155);
        expect_word(2, 10'h0AA);
        wait_valid(20);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("t3_hold_valid", valid_out, 1);
            check("t3_hold_data", data_out, 10'h155);
            check("t3_hold_dest", dest, 0);
            check("t3_hold_pops", {pop7, pop6, pop5, pop4}, 0);
        end
        @(posedge clk);
        #1;
        ready_in = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("t3_next_pop6", pop6, 1);
        check("t3_valid_dropped", valid_out, 0);
        wait_drain(20);

        // Clear coinciding with a FIFO 6 transfer at count2 = 7.
        do_reset();
        enable = 1'b1;
        ready_in = 1'b1;
        for (int i = 0; i < 7; i++) begin
            load(2, 10'(i + 40));
            expect_word(2, 10'(i + 40));
        end
        wait_drain(100);
        check("t4_count2_pre", count2, 7);
        ready_in = 1'b0;
        load(2, 10'h3C3);
        expect_word(2, 10'h3C3);
        wait_valid(20);
        @(posedge clk);
        #1;
        ready_in = 1'b1;
        clear_counts = 1'b1;
        @(posedge clk);
        #1;
        clear_counts = 1'b0;
        @(negedge clk);
        check("t4_count2_clear", count2, 0);
        check("t4_valid_after", valid_out, 0);
        wait_drain(20);

        // Counter wrap: 256 transfers from FIFO 7.
        do_reset();
        enable = 1'b1;
        ready_in = 1'b1;
        for (int i = 0; i < 255; i++) begin
            load(3, 10'(i));
            expect_word(3, 10'(i));
        end
        wait_drain(1000);
        check("t4_count3_255", count3, 255);
        load(3, 10'h3FF);
        expect_word(3, 10'h3FF);
        wait_drain(20);
        check("t4_count3_wrap", count3, 0);

        // enable dropped during POP: word completes, no further pops.
        do_reset();
        enable = 1'b1;
        ready_in = 1'b1;
        load(0, 10'h111);
        load(0, 10'h222);
        expect_word(0, 10'h111);
        begin
            int n;
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (!pop4 && n < 10);
            if (!pop4) check("t5_pop_timeout", 0, 1);
        end
        enable = 1'b0;
        wait_drain(20);
        repeat (10) @(negedge clk);
        check("t5_single_pop", pop_cyc.size(), 1);
        check("t5_idle", idle, 1);
        check("t5_count0", count0, 1);

        // Asynchronous reset while in SEND.
        do_reset();
        enable = 1'b1;
        ready_in = 1'b1;
        load(1, 10'h0F0);
        load(1, 10'h00F);
        expect_word(1, 10'h0F0);
        expect_word(1, 10'h00F);
        begin
            int n;
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (count1 != 1 && n < 20);
            if (count1 != 1) check("t6_count_timeout", 0, 1);
        end
        ready_in = 1'b0;
        wait_valid(10);
        #2;
        reset = 1'b0;
        #1;
        check("t6_rst_valid", valid_out, 0);
        check("t6_rst_idle", idle, 1);
        check("t6_rst_count1", count1, 0);
        check("t6_rst_pops", {pop7, pop6, pop5, pop4}, 0);
        do_reset();
        repeat (5) @(negedge clk);
        check("t6_no_reissue", pop_cyc.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
